// File: rtl/md5_auth_pkg.sv
// Shared types and constants for the MD5 password-authentication sequencer.
package md5_auth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_CMP  = 3'd4
  } state_t;

  localparam int unsigned MD5_BLOCK_WORDS = 16;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;
  localparam int unsigned MD5_LEN_WORD    = 14;
  localparam int unsigned DIGEST_W        = 128;

endpackage : md5_auth_pkg

// File: rtl/md5_pad_word.sv
// Combinational generator of one 32-bit word of the padded MD5 block for a
// short password made of single-bit characters (one byte per character).
module md5_pad_word
  import md5_auth_pkg::*;
#(
  parameter int unsigned NUM_CHARS = 4
) (
  input  logic [NUM_CHARS-1:0] i_chars,
  input  logic [3:0]           i_idx,
  output logic [31:0]          o_word_c
);

  // Byte k of the block: char bytes, then the pad byte, zero fill; the length
  // fits in the low byte of word 14 because the password is at most 7 bytes.
  always_comb begin
    o_word_c = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned c = 0; c < NUM_CHARS; c++) begin
        if ({i_idx, 2'(b)} == 6'(c)) o_word_c[8*b +: 8] = {7'b0, i_chars[NUM_CHARS-1-c]};
      end
      if ({i_idx, 2'(b)} == 6'(NUM_CHARS)) o_word_c[8*b +: 8] = MD5_PAD_BYTE;
    end
    if (i_idx == 4'(MD5_LEN_WORD)) o_word_c = 32'(NUM_CHARS * 8);
  end

endmodule : md5_pad_word

// File: rtl/md5_auth_sequencer.sv
// Password-authentication sequencer: latches the password and reference
// digest, streams the padded MD5 block to the core, starts the core and
// compares its digest. Optional lockout: define MD5_AUTH_LOCKOUT_EN.
module md5_auth_sequencer
  import md5_auth_pkg::*;
#(
  parameter int unsigned NUM_CHARS   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned LOCK_LIMIT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CHARS-1:0] char_bits,
  input  logic [DIGEST_W-1:0]  ref_digest,
  output logic [31:0]          msg_word,
  output logic [3:0]           msg_idx,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [DIGEST_W-1:0]  core_digest,
  output logic                 busy,
  output logic                 match_valid,
  output logic                 match,
  output logic                 timeout_err,
  output logic                 locked
);

  localparam int unsigned TCW      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [3:0]  LAST_IDX = 4'(MD5_BLOCK_WORDS - 1);

  if (NUM_CHARS < 1 || NUM_CHARS > 7 || TIMEOUT_CYC < 2 || LOCK_LIMIT < 1) begin : g_param_err
    $error("md5_auth_sequencer: parameter out of range");
  end

  state_t               r_state, w_state_nxt;
  logic [NUM_CHARS-1:0] r_chars, w_chars_nxt;
  logic [DIGEST_W-1:0]  r_ref;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [TCW-1:0]       r_tcnt;
  logic [31:0]          w_pad_word;
  logic                 w_lock_blk, w_start_ok, w_eq, w_tmo;
  logic                 w_msg_valid_nxt, w_core_start_nxt, w_busy_nxt;
  logic                 w_match_valid_nxt, w_match_nxt, w_timeout_nxt;
  logic [31:0]          w_msg_word_nxt;

  assign w_start_ok = start & ~w_lock_blk;
  assign w_eq       = (core_digest == r_ref);
  assign w_tmo      = ((r_tcnt + TCW'(1)) == TCW'(TIMEOUT_CYC - 1));

  // Word generator runs on next-cycle index/chars so msg_word can be registered.
  md5_pad_word #(.NUM_CHARS(NUM_CHARS)) u_pad (
    .i_chars  (w_chars_nxt),
    .i_idx    (w_idx_nxt),
    .o_word_c (w_pad_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus next password latch and word index.
  always_comb begin
    w_state_nxt = r_state;
    w_chars_nxt = r_chars;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: if (w_start_ok) begin
        w_state_nxt = ST_LOAD;
        w_chars_nxt = char_bits;
        w_idx_nxt   = '0;
      end
      ST_LOAD: if (msg_ready) begin
        if (r_idx == LAST_IDX) w_state_nxt = ST_RUN;
        else                   w_idx_nxt   = r_idx + 4'd1;
      end
      ST_RUN:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done)  w_state_nxt = ST_CMP;
        else if (w_tmo) w_state_nxt = ST_IDLE;
      end
      ST_CMP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    w_msg_valid_nxt   = (w_state_nxt == ST_LOAD);
    w_msg_word_nxt    = w_msg_valid_nxt ? w_pad_word : '0;
    w_core_start_nxt  = (w_state_nxt == ST_RUN);
    w_busy_nxt        = (w_state_nxt != ST_IDLE);
    w_match_valid_nxt = (w_state_nxt == ST_CMP);
    w_match_nxt       = (r_state == ST_WAIT && core_done) ? w_eq : match;
    w_timeout_nxt     = (r_state == ST_WAIT && w_state_nxt == ST_IDLE);
  end

  // Output registers and attempt datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_word    <= '0;
      msg_valid   <= 1'b0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      match_valid <= 1'b0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
      r_idx       <= '0;
      r_chars     <= '0;
      r_ref       <= '0;
      r_tcnt      <= '0;
    end else begin
      msg_word    <= w_msg_word_nxt;
      msg_valid   <= w_msg_valid_nxt;
      core_start  <= w_core_start_nxt;
      busy        <= w_busy_nxt;
      match_valid <= w_match_valid_nxt;
      match       <= w_match_nxt;
      timeout_err <= w_timeout_nxt;
      r_idx       <= w_idx_nxt;
      r_chars     <= w_chars_nxt;
      if (r_state == ST_IDLE && w_start_ok) r_ref <= ref_digest;
      if (r_state == ST_RUN)       r_tcnt <= '0;
      else if (r_state == ST_WAIT) r_tcnt <= r_tcnt + TCW'(1);
    end
  end

  assign msg_idx = r_idx;

`ifdef MD5_AUTH_LOCKOUT_EN
  localparam int unsigned LCW = $clog2(LOCK_LIMIT + 1) + 1;

  logic [LCW-1:0] r_fail_cnt, w_fail_nxt;
  logic           r_locked;

  // Consecutive-mismatch count; a match clears it, a timeout leaves it alone.
  always_comb begin
    w_fail_nxt = r_fail_cnt;
    if (r_state == ST_WAIT && core_done) begin
      if (w_eq)                                w_fail_nxt = '0;
      else if (r_fail_cnt < LCW'(LOCK_LIMIT))  w_fail_nxt = r_fail_cnt + LCW'(1);
    end
  end

  // Lockout register; only reset releases it since no attempt can run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fail_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_fail_cnt <= w_fail_nxt;
      r_locked   <= (w_fail_nxt >= LCW'(LOCK_LIMIT));
    end
  end

  assign w_lock_blk = r_locked;
  assign locked     = r_locked;
`else
  assign w_lock_blk = 1'b0;
  assign locked     = 1'b0;
`endif

endmodule : md5_auth_sequencer
